// File: rtl/pin_ser_pkg.sv
// Shared types and frame-length helper for the pin_ser serializer and its monitors.
package pin_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } ser_state_t;

  // Clock cycles from start bit through last gap cycle for one word.
  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned gap_bits);
    return 32'd1 + data_w + gap_bits;
  endfunction

endpackage

// File: rtl/pin_ser_shift_reg.sv
// Loadable shift register feeding the serial pin; head_o is the next bit to send.
module ser_shift_reg #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk300,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              head_o
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;

  // Load wins over shift; vacated positions fill with zero.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[DATA_W-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[DATA_W-1:1]};
      end
    end
  end

  // Shift register state.
  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign head_o = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];

endmodule

// File: rtl/pin_ser.sv
// Transmit serializer: start bit, DATA_W data bits, GAP_BITS idle cycles per word,
// with frame strobe and bit-index outputs matching the pin_capt capture side.
module pin_ser
  import pin_ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GAP_BITS  = 2,
  parameter logic        IDLE_LVL  = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                      clk300,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  output logic                      pin_out,
  output logic                      str,
  output logic [$clog2(DATA_W)-1:0] ptime,
  output logic                      busy
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned GAP_W = $clog2(GAP_BITS + 1);

  ser_state_t       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             pin_q, pin_d;
  logic             str_q, str_d;
  logic [BIT_W-1:0] ptime_q, ptime_d;
  logic             busy_q, busy_d;
  logic             rdy_en_q;
  logic             load_en;
  logic             shift_en;
  logic             head_bit;
  logic             gap_last;
  logic             xfer;

  ser_shift_reg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk300  (clk300),
    .rst_n   (rst_n),
    .load_i  (load_en),
    .shift_i (shift_en),
    .data_i  (data_in),
    .head_o  (head_bit)
  );

  // Ready depends on state only; held low until the first edge after reset.
  assign gap_last   = (state_q == GAP) && (gap_cnt_q == GAP_W'(GAP_BITS - 1));
  assign data_ready = rdy_en_q && ((state_q == IDLE) || gap_last);
  assign xfer       = data_valid && data_ready;

  // Next state and next pin/strobe/index values; outputs describe the coming cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pin_d     = IDLE_LVL;
    str_d     = 1'b0;
    ptime_d   = '0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = START;
          pin_d   = ~IDLE_LVL;
          load_en = 1'b1;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
        pin_d     = head_bit;
        shift_en  = 1'b1;
        str_d     = 1'b1;
      end
      DATA: begin
        if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
          state_d   = GAP;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          ptime_d   = bit_cnt_q + BIT_W'(1);
          pin_d     = head_bit;
          shift_en  = 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          if (xfer) begin
            state_d = START;
            pin_d   = ~IDLE_LVL;
            load_en = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered pin-side outputs.
  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      pin_q     <= IDLE_LVL;
      str_q     <= 1'b0;
      ptime_q   <= '0;
      busy_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pin_q     <= pin_d;
      str_q     <= str_d;
      ptime_q   <= ptime_d;
      busy_q    <= busy_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign pin_out = pin_q;
  assign str     = str_q;
  assign ptime   = ptime_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pin_ser.sv
// Directed bench for pin_ser: MSB-first instance (a) with a capture monitor,
// LSB-first instance (b).
module tb_pin_ser;
  import pin_ser_pkg::*;

  logic       clk300 = 1'b0;
  logic       rst_n;
  logic       dv_a, dv_b;
  logic [7:0] din_a, din_b;
  logic       rdy_a, pin_a, str_a, busy_a;
  logic       rdy_b, pin_b, str_b, busy_b;
  logic [2:0] pt_a, pt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk300 = ~clk300;

  pin_ser u_dut_a (
    .clk300     (clk300),
    .rst_n      (rst_n),
    .data_in    (din_a),
    .data_valid (dv_a),
    .data_ready (rdy_a),
    .pin_out    (pin_a),
    .str        (str_a),
    .ptime      (pt_a),
    .busy       (busy_a)
  );

  pin_ser #(.MSB_FIRST(1'b0)) u_dut_b (
    .clk300     (clk300),
    .rst_n      (rst_n),
    .data_in    (din_b),
    .data_valid (dv_b),
    .data_ready (rdy_b),
    .pin_out    (pin_b),
    .str        (str_b),
    .ptime      (pt_b),
    .busy       (busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic dv, input logic [7:0] d);
    if (sel) begin
      dv_b  = dv;
      din_b = d;
    end else begin
      dv_a  = dv;
      din_a = d;
    end
  endtask

  task automatic sample(input bit sel, output logic p, output logic s, output logic [2:0] t,
                        output logic b, output logic r);
    if (sel) begin
      p = pin_b; s = str_b; t = pt_b; b = busy_b; r = rdy_b;
    end else begin
      p = pin_a; s = str_a; t = pt_a; b = busy_a; r = rdy_a;
    end
  endtask

  // Walks one whole frame after the transfer edge; exp_ser[7] is the first data bit sent.
  task automatic check_frame(input bit sel, input logic [7:0] exp_ser, input bit keep,
                             input logic [7:0] next_d);
    int unsigned n;
    logic p, s, b, r;
    logic [2:0] t;
    logic e_pin, e_str, e_rdy;
    logic [2:0] e_pt;
    n = frame_len(8, 2);
    for (int c = 1; c <= int'(n); c++) begin
      @(negedge clk300);
      sample(sel, p, s, t, b, r);
      e_pin = 1'b0; e_str = 1'b0; e_pt = 3'd0; e_rdy = 1'b0;
      if (c == 1) begin
        e_pin = 1'b1;
      end else if (c <= 9) begin
        e_pin = exp_ser[9-c];
        e_str = (c == 2);
        e_pt  = 3'(c - 2);
      end
      if (c == int'(n)) e_rdy = 1'b1;
      chk($sformatf("pin d%0d c%0d", sel, c), p, e_pin);
      chk($sformatf("str d%0d c%0d", sel, c), s, e_str);
      chk($sformatf("ptime d%0d c%0d", sel, c), t, e_pt);
      chk($sformatf("busy d%0d c%0d", sel, c), b, 1'b1);
      chk($sformatf("ready d%0d c%0d", sel, c), r, e_rdy);
      if (c == 1) set_in(sel, keep, next_d);
    end
  endtask

  // Capture-side monitor on instance a: rebuilds words from str/pin and tracks ptime.
  logic [7:0] cap_word;
  int         cap_idx;
  bit         cap_on = 1'b0;
  logic [7:0] cap_q[$];

  always @(negedge clk300) begin
    if (!rst_n) begin
      cap_on = 1'b0;
    end else if (str_a) begin
      chk("mon ptime first", pt_a, 0);
      cap_on   = 1'b1;
      cap_word = {7'b0, pin_a};
      cap_idx  = 1;
    end else if (cap_on) begin
      chk($sformatf("mon ptime bit%0d", cap_idx), pt_a, cap_idx);
      cap_word = {cap_word[6:0], pin_a};
      cap_idx++;
      if (cap_idx == 8) begin
        cap_q.push_back(cap_word);
        cap_on = 1'b0;
      end
    end
  end

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic [7:0] exp_ser;
    bit         keep;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] loop_w[3];
    bit prev_keep;
    bit found;

    vecs[0] = '{1'b0, 8'hA5, 8'b1010_0101, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 8'b0011_1100, 1'b1};
    vecs[2] = '{1'b0, 8'hC3, 8'b1100_0011, 1'b0};
    vecs[3] = '{1'b1, 8'h01, 8'b1000_0000, 1'b0};
    vecs[4] = '{1'b1, 8'h0D, 8'b1011_0000, 1'b0};

    rst_n = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk300);
    chk("rst ready a", rdy_a, 1'b0);
    chk("rst ready b", rdy_b, 1'b0);
    chk("rst pin a", pin_a, 1'b0);
    chk("rst busy a", busy_a, 1'b0);
    chk("rst str a", str_a, 1'b0);
    chk("rst ptime a", pt_a, 3'd0);
    rst_n = 1'b1;

    // Idle with no valid: line stays low, ready after first edge.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk300);
      chk($sformatf("idle pin a %0d", i), pin_a, 1'b0);
      chk($sformatf("idle busy a %0d", i), busy_a, 1'b0);
      chk($sformatf("idle ready a %0d", i), rdy_a, 1'b1);
      chk($sformatf("idle str a %0d", i), str_a, 1'b0);
      chk($sformatf("idle ready b %0d", i), rdy_b, 1'b1);
    end

    // Vector table: single words, back-to-back pair, LSB-first instance.
    prev_keep = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!prev_keep) begin
        @(negedge clk300);
        set_in(vecs[i].sel, 1'b1, vecs[i].data);
      end
      chk($sformatf("vec%0d ready", i), vecs[i].sel ? rdy_b : rdy_a, 1'b1);
      check_frame(vecs[i].sel, vecs[i].exp_ser, vecs[i].keep,
                  (vecs[i].keep && i < 4) ? vecs[i+1].data : ~vecs[i].data);
      prev_keep = vecs[i].keep;
    end

    // Reset in the middle of 0xFF, at data bit 4.
    @(negedge clk300);
    set_in(0, 1'b1, 8'hFF);
    @(negedge clk300);
    set_in(0, 1'b0, 8'h00);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (busy_a && pt_a == 3'd4) found = 1'b1;
      else @(negedge clk300);
    end
    chk("reach data bit 4", found, 1'b1);
    chk("pin before reset", pin_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst pin", pin_a, 1'b0);
    chk("midrst busy", busy_a, 1'b0);
    chk("midrst str", str_a, 1'b0);
    chk("midrst ptime", pt_a, 3'd0);
    chk("midrst ready", rdy_a, 1'b0);
    repeat (2) @(negedge clk300);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk300);
      chk($sformatf("postrst pin %0d", i), pin_a, 1'b0);
      chk($sformatf("postrst busy %0d", i), busy_a, 1'b0);
      chk($sformatf("postrst ready %0d", i), rdy_a, 1'b1);
    end
    set_in(0, 1'b1, 8'h96);
    check_frame(0, 8'b1001_0110, 1'b0, 8'h00);

    // Loopback capture of three words.
    @(negedge clk300);
    cap_q.delete();
    loop_w[0] = 8'h00;
    loop_w[1] = 8'hFF;
    loop_w[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk300);
      set_in(0, 1'b1, loop_w[i]);
      check_frame(0, loop_w[i], 1'b0, 8'h00);
    end
    @(negedge clk300);
    chk("loop count", cap_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : 8'hxx;
      chk($sformatf("loop word %0d", i), got, loop_w[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
